// File: rtl/qpd_synth_pkg.sv
// Shared widths, FSM encoding and saturation helper for the QPD signal synthesizer.
package qpd_synth_pkg;

    // Default widths and Q-format fractional bit counts
    localparam int QPD_DATA_W     = 16;
    localparam int QPD_DATA_FRAC  = 15;
    localparam int QPD_COEFF_W    = 10;
    localparam int QPD_COEFF_FRAC = 8;
    localparam int QPD_DIV_W      = 16;

    // Width of the intermediate used when clamping sums to the data range
    localparam int SAT_IN_W = 40;

    // Ramp controller states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_e;

    // Clamp a wide signed value to the signed range of a w-bit word.
    // The result stays SAT_IN_W wide; callers keep the low w bits.
    function automatic logic signed [SAT_IN_W-1:0] sat_wide(
        input logic signed [SAT_IN_W-1:0] v,
        input int                         w
    );
        logic signed [SAT_IN_W-1:0] hi;
        logic signed [SAT_IN_W-1:0] lo;
        hi = (SAT_IN_W'(1) <<< (w - 1)) - SAT_IN_W'(1);
        lo = ~hi;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/sat_frac_mult.sv
// Signed fractional multiplier: a*b at full precision, arithmetic shift
// right (floor), saturate to OUT_W, one register stage loaded when en is high.
module sat_frac_mult #(
    parameter int A_W   = 16,
    parameter int B_W   = 10,
    parameter int SHIFT = 8,
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic signed [A_W-1:0]   a_i,
    input  logic signed [B_W-1:0]   b_i,
    output logic signed [OUT_W-1:0] y_o
);

    localparam int P_W = A_W + B_W;
    localparam logic signed [OUT_W-1:0] Y_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] Y_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic        [P_W-1:0]   a_ext;
    logic        [P_W-1:0]   b_ext;
    logic signed [P_W-1:0]   prod;
    logic signed [P_W-1:0]   shifted;
    logic signed [OUT_W-1:0] y_d;

    // Product, floor shift and clamp; overflow shows as non-uniform upper bits
    always_comb begin
        a_ext   = {{B_W{a_i[A_W-1]}}, a_i};
        b_ext   = {{A_W{b_i[B_W-1]}}, b_i};
        prod    = a_ext * b_ext;
        shifted = prod >>> SHIFT;
        if (shifted[P_W-1:OUT_W-1] != {(P_W-OUT_W+1){shifted[P_W-1]}}) begin
            y_d = shifted[P_W-1] ? Y_MIN : Y_MAX;
        end else begin
            y_d = shifted[OUT_W-1:0];
        end
    end

    // Result register holds its value until the next enabled load
    always_ff @(posedge clk) begin
        if (reset) begin
            y_o <= '0;
        end else if (en) begin
            y_o <= y_d;
        end
    end

endmodule

// File: rtl/qpd_signal_synth.sv
// Quadrant-photodiode plant emulator: slews bead position toward commanded
// targets and synthesizes XDIFF/YDIFF/SUM through a three-stage pipeline.
// Handshake: a target is transferred on a cycle where target_valid and
// target_ready are both high; target_ready is high only in IDLE out of reset.
module qpd_signal_synth
    import qpd_synth_pkg::*;
#(
    parameter int DATA_W     = QPD_DATA_W,
    parameter int DATA_FRAC  = QPD_DATA_FRAC,
    parameter int COEFF_W    = QPD_COEFF_W,
    parameter int COEFF_FRAC = QPD_COEFF_FRAC,
    parameter int DIV_W      = QPD_DIV_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic        [DIV_W-1:0]   sample_div,
    input  logic signed [DATA_W-1:0]  target_x,
    input  logic signed [DATA_W-1:0]  target_y,
    input  logic signed [DATA_W-1:0]  target_z,
    input  logic                      target_valid,
    output logic                      target_ready,
    input  logic        [DATA_W-1:0]  step_limit,
    input  logic signed [DATA_W-1:0]  sum_base,
    input  logic signed [COEFF_W-1:0] sum_slope,
    input  logic signed [COEFF_W-1:0] diff_gain,
    input  logic signed [DATA_W-1:0]  feedback,
    input  logic                      feedback_valid,
    input  logic signed [COEFF_W-1:0] feedback_gain,
    output logic signed [DATA_W-1:0]  XDIFF,
    output logic signed [DATA_W-1:0]  YDIFF,
    output logic signed [DATA_W-1:0]  SUM,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      at_target
);

    // Move pos toward tgt by at most lim; lim of zero means jump. The delta
    // is one bit wider than the data so opposite-sign endpoints cannot wrap.
    function automatic logic signed [DATA_W-1:0] step_toward(
        input logic signed [DATA_W-1:0] pos,
        input logic signed [DATA_W-1:0] tgt,
        input logic        [DATA_W-1:0] lim
    );
        logic signed [DATA_W:0] delta;
        logic        [DATA_W:0] mag;
        delta = {tgt[DATA_W-1], tgt} - {pos[DATA_W-1], pos};
        mag   = delta[DATA_W] ? -delta : delta;
        if (lim == '0 || mag <= {1'b0, lim}) return tgt;
        if (delta[DATA_W]) return pos - lim;
        return pos + lim;
    endfunction

    state_e                    state_q, state_d;
    logic        [DIV_W-1:0]   cnt_q, cnt_d;
    logic                      tick;
    logic                      accept;
    logic                      all_eq;
    logic signed [DATA_W-1:0]  tgt_in [3];
    logic signed [DATA_W-1:0]  tgt_q  [3];
    logic signed [DATA_W-1:0]  pos_q  [3];
    logic signed [DATA_W-1:0]  pos_d  [3];
    logic signed [DATA_W-1:0]  fb_offset;
    logic signed [SAT_IN_W-1:0] xe_wide, sum_wide;
    logic signed [DATA_W-1:0]  xe_d, xe_q, ye_q;
    logic signed [DATA_W+1:0]  slope_q;
    logic signed [DATA_W-1:0]  sum_s1, sum2_q, sum3_q;
    logic signed [DATA_W-1:0]  xs_q, ys_q;
    logic                      v1_q, v2_q, v3_q;

    assign tgt_in[0] = target_x;
    assign tgt_in[1] = target_y;
    assign tgt_in[2] = target_z;
    assign accept    = target_valid && target_ready;
    assign all_eq    = (pos_q[0] == tgt_q[0]) && (pos_q[1] == tgt_q[1]) && (pos_q[2] == tgt_q[2]);

    // Sample divider: tick when the count reaches sample_div, idle when disabled
    always_comb begin
        tick  = enable && (cnt_q >= sample_div);
        cnt_d = (!enable || tick) ? '0 : cnt_q + 1'b1;
    end

    // Divider count register
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: accept in IDLE, leave RAMP the cycle after arrival
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RAMP;
            ST_RAMP: if (all_eq) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; ready is held low while reset is asserted
    always_comb begin
        target_ready = (state_q == ST_IDLE) && !reset;
        busy         = (state_q == ST_RAMP);
        at_target    = (state_q == ST_IDLE);
    end

    // Per-axis slew on each tick while ramping
    always_comb begin
        pos_d = pos_q;
        if (state_q == ST_RAMP && tick) begin
            for (int i = 0; i < 3; i++) pos_d[i] = step_toward(pos_q[i], tgt_q[i], step_limit);
        end
    end

    // Position and latched target registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                pos_q[i] <= '0;
                tgt_q[i] <= '0;
            end
        end else begin
            pos_q <= pos_d;
            if (accept) tgt_q <= tgt_in;
        end
    end

    // Feedback displacement, updated whenever the controller presents a value
    sat_frac_mult #(.A_W(DATA_W), .B_W(COEFF_W), .SHIFT(COEFF_FRAC), .OUT_W(DATA_W)) u_fb (
        .clk(clk), .reset(reset), .en(feedback_valid),
        .a_i(feedback), .b_i(feedback_gain), .y_o(fb_offset)
    );

    // S1 z-slope term; two extra bits keep the product exact before the add
    sat_frac_mult #(.A_W(DATA_W), .B_W(COEFF_W), .SHIFT(COEFF_FRAC), .OUT_W(DATA_W + 2)) u_slope (
        .clk(clk), .reset(reset), .en(tick),
        .a_i(pos_d[2]), .b_i(sum_slope), .y_o(slope_q)
    );

    // S1 effective x (position plus feedback) and S2 sum, both clamped
    always_comb begin
        xe_wide  = sat_wide(SAT_IN_W'(pos_d[0]) + SAT_IN_W'(fb_offset), DATA_W);
        xe_d     = xe_wide[DATA_W-1:0];
        sum_wide = sat_wide(SAT_IN_W'(sum_base) + SAT_IN_W'(slope_q), DATA_W);
        sum_s1   = sum_wide[DATA_W-1:0];
    end

    // Pipeline data and valid registers; reset drops any in-flight sample
    always_ff @(posedge clk) begin
        if (reset) begin
            xe_q   <= '0;
            ye_q   <= '0;
            sum2_q <= '0;
            sum3_q <= '0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
        end else begin
            v1_q <= tick;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (tick) begin
                xe_q <= xe_d;
                ye_q <= pos_d[1];
            end
            if (v1_q) sum2_q <= sum_s1;
            if (v2_q) sum3_q <= sum2_q;
        end
    end

    // S2 scale positions by SUM (Q1.15)
    sat_frac_mult #(.A_W(DATA_W), .B_W(DATA_W), .SHIFT(DATA_FRAC), .OUT_W(DATA_W)) u_xs (
        .clk(clk), .reset(reset), .en(v1_q), .a_i(xe_q), .b_i(sum_s1), .y_o(xs_q)
    );
    sat_frac_mult #(.A_W(DATA_W), .B_W(DATA_W), .SHIFT(DATA_FRAC), .OUT_W(DATA_W)) u_ys (
        .clk(clk), .reset(reset), .en(v1_q), .a_i(ye_q), .b_i(sum_s1), .y_o(ys_q)
    );

    // S3 diff-channel gain; these registers are the held outputs
    sat_frac_mult #(.A_W(DATA_W), .B_W(COEFF_W), .SHIFT(COEFF_FRAC), .OUT_W(DATA_W)) u_xd (
        .clk(clk), .reset(reset), .en(v2_q), .a_i(xs_q), .b_i(diff_gain), .y_o(XDIFF)
    );
    sat_frac_mult #(.A_W(DATA_W), .B_W(COEFF_W), .SHIFT(COEFF_FRAC), .OUT_W(DATA_W)) u_yd (
        .clk(clk), .reset(reset), .en(v2_q), .a_i(ys_q), .b_i(diff_gain), .y_o(YDIFF)
    );

    assign SUM       = sum3_q;
    assign out_valid = v3_q;

endmodule

// File: tb/tb_qpd_signal_synth.sv
// Directed plus randomized bench for qpd_signal_synth against a behavioural model.
module tb_qpd_signal_synth;

  logic               clk;
  logic               reset;
  logic               enable;
  logic        [15:0] sample_div;
  logic signed [15:0] target_x, target_y, target_z;
  logic               target_valid;
  logic               target_ready;
  logic        [15:0] step_limit;
  logic signed [15:0] sum_base;
  logic signed [9:0]  sum_slope, diff_gain, feedback_gain;
  logic signed [15:0] feedback;
  logic               feedback_valid;
  logic signed [15:0] XDIFF, YDIFF, SUM;
  logic               out_valid, busy, at_target;

  qpd_signal_synth dut (
    .clk(clk), .reset(reset), .enable(enable), .sample_div(sample_div),
    .target_x(target_x), .target_y(target_y), .target_z(target_z),
    .target_valid(target_valid), .target_ready(target_ready),
    .step_limit(step_limit), .sum_base(sum_base), .sum_slope(sum_slope),
    .diff_gain(diff_gain), .feedback(feedback), .feedback_valid(feedback_valid),
    .feedback_gain(feedback_gain), .XDIFF(XDIFF), .YDIFF(YDIFF), .SUM(SUM),
    .out_valid(out_valid), .busy(busy), .at_target(at_target)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  typedef struct { int due; int x; int y; int s; } samp_t;
  samp_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  // behavioural model state
  bit m_ramp;
  int m_cnt, m_fb, m_cyc;
  int m_pos[3];
  int m_tgt[3];
  int exp_x, exp_y, exp_s, exp_ov;

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] expv);
    n_cmp++;
    assert (got === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, expv);
    end
  endtask

  // Advance the model by one clock using the inputs presented this cycle
  task automatic model_update();
    int  d, lim, sd;
    bit  tk, acc;
    samp_t s;
    longint sum, xe, xs, ys;
    m_cyc++;
    if (reset) begin
      m_ramp = 0; m_cnt = 0; m_fb = 0;
      for (int i = 0; i < 3; i++) begin m_pos[i] = 0; m_tgt[i] = 0; end
      exp_q.delete();
      exp_x = 0; exp_y = 0; exp_s = 0; exp_ov = 0;
      return;
    end
    sd  = int'(sample_div);
    lim = int'(step_limit);
    tk  = enable && (m_cnt >= sd);
    acc = target_valid && !m_ramp;
    m_cnt = (!enable || tk) ? 0 : m_cnt + 1;
    if (m_ramp) begin
      if (m_pos[0] == m_tgt[0] && m_pos[1] == m_tgt[1] && m_pos[2] == m_tgt[2]) m_ramp = 0;
      else if (tk) begin
        for (int i = 0; i < 3; i++) begin
          d = m_tgt[i] - m_pos[i];
          if (lim == 0 || (d < 0 ? -d : d) <= lim) m_pos[i] = m_tgt[i];
          else m_pos[i] += (d < 0) ? -lim : lim;
        end
      end
    end else if (acc) begin
      m_tgt[0] = int'(target_x); m_tgt[1] = int'(target_y); m_tgt[2] = int'(target_z);
      m_ramp = 1;
    end
    exp_ov = 0;
    if (exp_q.size() > 0 && exp_q[0].due == m_cyc) begin
      s = exp_q.pop_front();
      exp_ov = 1; exp_x = s.x; exp_y = s.y; exp_s = s.s;
    end
    if (tk) begin
      sum = sat16(longint'(sum_base) + ((longint'(m_pos[2]) * longint'(sum_slope)) >>> 8));
      xe  = sat16(longint'(m_pos[0]) + longint'(m_fb));
      xs  = sat16((xe * sum) >>> 15);
      ys  = sat16((longint'(m_pos[1]) * sum) >>> 15);
      s.due = m_cyc + 2;
      s.x = int'(sat16((xs * longint'(diff_gain)) >>> 8));
      s.y = int'(sat16((ys * longint'(diff_gain)) >>> 8));
      s.s = int'(sum);
      exp_q.push_back(s);
    end
    if (feedback_valid) m_fb = int'(sat16((longint'(feedback) * longint'(feedback_gain)) >>> 8));
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), exp_ov);
    chk("busy", 32'(busy), int'(m_ramp));
    chk("at_target", 32'(at_target), int'(!m_ramp));
    chk("target_ready", 32'(target_ready), int'(!reset && !m_ramp));
    chk("xdiff", 32'(XDIFF), exp_x);
    chk("ydiff", 32'(YDIFF), exp_y);
    chk("sum", 32'(SUM), exp_s);
  endtask

  // driver: one clock, sampled 1 time unit after the rising edge
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while (m_ramp && n < budget) begin step(); n++; end
    chk("ramp_finished_in_budget", 32'(busy), 0);
  endtask

  task automatic drain();
    enable = 1'b0;
    repeat (5) step();
  endtask

  task automatic pulse_feedback(input logic signed [15:0] v);
    feedback = v; feedback_valid = 1'b1; step(); feedback_valid = 1'b0;
  endtask

  task automatic offer(input logic signed [15:0] x, input logic signed [15:0] y, input logic signed [15:0] z);
    target_x = x; target_y = y; target_z = z; target_valid = 1'b1; step(); target_valid = 1'b0;
  endtask

  initial begin
    int guard, pulses;
    reset = 1'b1; enable = 1'b0; sample_div = 16'd4; step_limit = 16'd0;
    target_x = '0; target_y = '0; target_z = '0; target_valid = 1'b0;
    sum_base = 16'sh4000; sum_slope = '0; diff_gain = 10'sh100;
    feedback = '0; feedback_valid = 1'b0; feedback_gain = 10'sh100;
    m_ramp = 0; m_cnt = 0; m_fb = 0; m_cyc = 0;
    exp_x = 0; exp_y = 0; exp_s = 0; exp_ov = 0;
    for (int i = 0; i < 3; i++) begin m_pos[i] = 0; m_tgt[i] = 0; end

    // reset
    repeat (3) step();
    reset = 1'b0;
    step();

    // free-running samples at zero position
    enable = 1'b1;
    repeat (20) step();
    chk("idle_sum", 32'(SUM), 16384);
    chk("idle_xdiff", 32'(XDIFF), 0);

    // positive ramp in 0x400 steps
    step_limit = 16'h0400;
    offer(16'sh1000, 16'sh0000, 16'sh0000);
    run_until_idle(200);
    repeat (12) step();
    chk("ramp_up_xdiff", 32'(XDIFF), 2048);

    // negative ramp ending in a partial snap
    step_limit = 16'h0700;
    offer(-16'sh1000, 16'sh0000, 16'sh0000);
    run_until_idle(200);
    repeat (12) step();
    chk("ramp_down_xdiff", 32'(XDIFF), -2048);

    // saturation of xe and of the S2 product
    drain();
    sum_base = 16'sh7FFF;
    pulse_feedback(16'sh4000);
    step_limit = 16'h0000;
    offer(16'sh7000, 16'sh0000, 16'sh0000);
    enable = 1'b1;
    repeat (20) step();
    chk("sat_xdiff", 32'(XDIFF), 32766);
    drain();
    pulse_feedback(-16'sh8000);
    enable = 1'b1;
    repeat (20) step();
    chk("floor_xdiff", 32'(XDIFF), -4096);

    // target held valid during a ramp is taken on the first IDLE cycle
    drain();
    sum_base = 16'sh4000;
    pulse_feedback(16'sh0000);
    enable = 1'b1;
    step_limit = 16'h1000;
    offer(16'sh0000, 16'sh0100, -16'sh0100);
    target_x = 16'sh0800; target_valid = 1'b1;
    run_until_idle(400);
    step();
    chk("accept_first_idle", 32'(busy), 1);
    target_valid = 1'b0;
    run_until_idle(400);

    // reset mid-ramp aborts ramp and in-flight samples
    step_limit = 16'h0200;
    offer(16'sh7000, 16'sh3000, 16'sh1000);
    repeat (12) step();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    repeat (15) step();
    chk("post_reset_xdiff", 32'(XDIFF), 0);

    // lowering sample_div below the count ticks immediately
    enable = 1'b0; sample_div = 16'd10;
    step();
    enable = 1'b1;
    guard = 0;
    while (m_cnt != 7 && guard < 50) begin step(); guard++; end
    chk("count_reached", guard < 50, 1);
    sample_div = 16'd3;
    repeat (3) step();
    chk("lowered_div_tick", 32'(out_valid), 1);

    // disabling mid-ramp freezes positions but lets the pending sample out
    sample_div = 16'd4;
    repeat (6) step();
    step_limit = 16'h0100;
    offer(-16'sh7000, 16'sh0000, 16'sh0000);
    guard = 0;
    while (exp_q.size() == 0 && guard < 20) begin step(); guard++; end
    enable = 1'b0;
    pulses = 0;
    repeat (10) begin step(); pulses += int'(out_valid); end
    chk("pending_sample_emitted", pulses, 1);
    chk("frozen_still_busy", 32'(busy), 1);
    enable = 1'b1;
    run_until_idle(2000);

    // randomized rounds
    for (int r = 0; r < 15; r++) begin
      drain();
      sum_base      = 16'($urandom_range(0, 65535));
      sum_slope     = 10'($urandom_range(0, 1023));
      diff_gain     = 10'($urandom_range(0, 1023));
      feedback_gain = 10'($urandom_range(0, 1023));
      sample_div    = 16'($urandom_range(0, 6));
      step_limit    = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(16'h0200, 16'h4000));
      pulse_feedback(16'($urandom_range(0, 65535)));
      enable = 1'b1;
      offer(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
      run_until_idle(2000);
      repeat ($urandom_range(10, 30)) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
